// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: opcodes, FSM encoding and the reset PC.
package fetch_sequencer_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_MEM  = 3'd1;
    localparam logic [2:0] ST_WAIT_Q    = 3'd2;
    localparam logic [2:0] ST_WAIT_JALR = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pred_pc;
        logic        taken;
        logic        is_jalr;
    } pred_t;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational next-PC prediction from the fetched instruction's opcode and immediate.
module fetch_target_calc
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        bht_bit_i,
    output pred_t       pred_o
);

    logic [31:0] j_imm;
    logic [31:0] b_imm;

    assign j_imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign b_imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

    always_comb begin
        pred_o.pred_pc = pc_i + 32'd4;
        pred_o.taken   = 1'b0;
        pred_o.is_jalr = 1'b0;
        case (inst_i[6:0])
            OPC_JAL:    pred_o.pred_pc = pc_i + j_imm;
            OPC_BRANCH: begin
                if (bht_bit_i) begin
                    pred_o.pred_pc = pc_i + b_imm;
                    pred_o.taken   = 1'b1;
                end
            end
            // JALR keeps pc+4 as a provisional value; the ROB supplies the real target.
            OPC_JALR:   pred_o.is_jalr = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch PC owner: icache request sequencing, next-PC prediction, flush/drain.
// Optional FETCH_BHT_EN adds a 2-bit saturating-counter branch history table.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    input  logic        iq_full,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pred_pc,
    output logic        out_pred_taken,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    input  logic        jalr_done_in,
`ifdef FETCH_BHT_EN
    input  logic        bht_upd_valid,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken,
`endif
    input  logic [31:0] jalr_target_in
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pred_pc_q, out_pred_pc_d;
    logic        out_taken_q, out_taken_d;
    logic        deliver;
    logic [31:0] cur_inst;
    logic        bht_bit;
    pred_t       pred;

`ifdef FETCH_BHT_EN
    localparam int BHT_N = 1 << BHT_IDX_W;
    logic [1:0]           bht_q [BHT_N];
    logic [BHT_IDX_W-1:0] upd_idx;

    assign upd_idx = bht_upd_pc[BHT_IDX_W+1:2];
    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    assign bht_bit = bht_q[pc_q[BHT_IDX_W+1:2]][1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (rdy_in && bht_upd_valid) begin
            if (bht_upd_taken && bht_q[upd_idx] != 2'b11)
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
            else if (!bht_upd_taken && bht_q[upd_idx] != 2'b00)
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
        end
    end
`else
    // Without a table every branch predicts taken.
    assign bht_bit = (BHT_IDX_W >= 0);
`endif

    assign cur_inst = (state_q == ST_WAIT_Q) ? inst_q : ic_resp_inst;

    fetch_target_calc u_calc (
        .pc_i      (pc_q),
        .inst_i    (cur_inst),
        .bht_bit_i (bht_bit),
        .pred_o    (pred)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        out_valid_d   = 1'b0;
        out_inst_d    = out_inst_q;
        out_pc_d      = out_pc_q;
        out_pred_pc_d = out_pred_pc_q;
        out_taken_d   = out_taken_q;
        deliver       = 1'b0;
        if (flush_in) begin
            pc_d        = flush_pc;
            req_valid_d = 1'b0;
            // An outstanding fetch must still be swallowed before refetching.
            if ((state_q == ST_WAIT_MEM || state_q == ST_DRAIN) && !ic_resp_valid)
                state_d = ST_DRAIN;
            else
                state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!iq_full) begin
                        req_valid_d = 1'b1;
                        req_addr_d  = pc_q;
                        state_d     = ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    if (ic_resp_valid) begin
                        req_valid_d = 1'b0;
                        inst_d      = ic_resp_inst;
                        if (iq_full) state_d = ST_WAIT_Q;
                        else         deliver = 1'b1;
                    end
                end
                ST_WAIT_Q:    if (!iq_full) deliver = 1'b1;
                ST_WAIT_JALR: begin
                    if (jalr_done_in) begin
                        pc_d    = jalr_target_in & ~32'h1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN:     if (ic_resp_valid) state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
            if (deliver) begin
                out_valid_d   = 1'b1;
                out_inst_d    = cur_inst;
                out_pc_d      = pc_q;
                out_pred_pc_d = pred.pred_pc;
                out_taken_d   = pred.taken;
                pc_d          = pred.pred_pc;
                state_d       = pred.is_jalr ? ST_WAIT_JALR : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            out_valid_q   <= 1'b0;
            out_inst_q    <= '0;
            out_pc_q      <= '0;
            out_pred_pc_q <= '0;
            out_taken_q   <= 1'b0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            out_valid_q   <= out_valid_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            out_pred_pc_q <= out_pred_pc_d;
            out_taken_q   <= out_taken_d;
        end
    end

    // A pulse pending across a stall is held and shown once rdy_in returns.
    assign out_valid      = out_valid_q & rdy_in;
    assign ic_req_valid   = req_valid_q;
    assign ic_req_addr    = req_addr_q;
    assign out_inst       = out_inst_q;
    assign out_pc         = out_pc_q;
    assign out_pred_pc    = out_pred_pc_q;
    assign out_pred_taken = out_taken_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_fetch_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, ic_resp_valid, iq_full, flush_in, jalr_done_in;
    logic [31:0] ic_resp_inst, flush_pc, jalr_target_in;
    logic        ic_req_valid, out_valid, out_pred_taken;
    logic [31:0] ic_req_addr, out_inst, out_pc, out_pred_pc;
`ifdef FETCH_BHT_EN
    logic        bht_upd_valid, bht_upd_taken;
    logic [31:0] bht_upd_pc;
`endif

    int vec  = 0;
    int errs = 0;

    localparam logic [31:0] I_ADDI  = 32'h0000_0013;
    localparam logic [31:0] I_ADDI1 = 32'h0010_0093;
    localparam logic [31:0] I_ADDI2 = 32'h0020_0113;
    localparam logic [31:0] I_JAL   = 32'h0200_00EF;
    localparam logic [31:0] I_BEQ   = 32'hFE00_0CE3;
    localparam logic [31:0] I_JALR  = 32'h0000_8067;

    always #5 clk_in = ~clk_in;

    fetch_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
        .iq_full(iq_full), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc(out_pc), .out_pred_pc(out_pred_pc), .out_pred_taken(out_pred_taken),
        .flush_in(flush_in), .flush_pc(flush_pc), .jalr_done_in(jalr_done_in),
`ifdef FETCH_BHT_EN
        .bht_upd_valid(bht_upd_valid), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
`endif
        .jalr_target_in(jalr_target_in)
    );

    // Flush with a simultaneous response lands in IDLE from any state; returns with the request visible.
    task automatic redirect(input logic [31:0] p);
        @(negedge clk_in);
        flush_in = 1'b1; flush_pc = p; ic_resp_valid = 1'b1; ic_resp_inst = I_ADDI;
        @(negedge clk_in);
        flush_in = 1'b0; ic_resp_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic respond(input logic [31:0] inst);
        ic_resp_valid = 1'b1; ic_resp_inst = inst;
        @(negedge clk_in);
        ic_resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b1; rdy_in = 1'b0; ic_resp_valid = 1'b0; ic_resp_inst = '0;
        iq_full = 1'b0; flush_in = 1'b0; flush_pc = '0; jalr_done_in = 1'b0; jalr_target_in = '0;
`ifdef FETCH_BHT_EN
        bht_upd_valid = 1'b0; bht_upd_pc = '0; bht_upd_taken = 1'b0;
`endif
        repeat (3) @(negedge clk_in);
        vec++; if (ic_req_valid !== 1'b0) begin errs++; $display("FAIL reset_req_valid: got %b want 0", ic_req_valid); end
        vec++; if (ic_req_addr !== 32'h0) begin errs++; $display("FAIL reset_req_addr: got %h want 0", ic_req_addr); end
        vec++; if (out_pc !== 32'h0 || out_pred_pc !== 32'h0 || out_inst !== 32'h0 || out_pred_taken !== 1'b0) begin
            errs++; $display("FAIL reset_outs: pc %h pred %h inst %h tk %b want all 0", out_pc, out_pred_pc, out_inst, out_pred_taken);
        end
        rdy_in = 1'b1; #1;
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        rst_in = 1'b0;
        @(negedge clk_in);
        vec++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0) begin
            errs++; $display("FAIL first_req: valid %b addr %h want 1 0", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_addi;
        respond(I_ADDI);
        vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_pred_pc !== 32'h4 || out_inst !== I_ADDI || out_pred_taken !== 1'b0) begin
            errs++; $display("FAIL addi_deliver: v %b pc %h pred %h inst %h tk %b want 1 0 4 13 0", out_valid, out_pc, out_pred_pc, out_inst, out_pred_taken);
        end
        @(negedge clk_in);
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL addi_pulse_width: got %b want 0", out_valid); end
        vec++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h4) begin
            errs++; $display("FAIL addi_next_req: valid %b addr %h want 1 4", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_jal;
        redirect(32'h100);
        vec++; if (ic_req_addr !== 32'h100) begin errs++; $display("FAIL jal_req: got %h want 100", ic_req_addr); end
        respond(I_JAL);
        vec++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_pred_pc !== 32'h120 || out_pred_taken !== 1'b0) begin
            errs++; $display("FAIL jal_pred: v %b pc %h pred %h tk %b want 1 100 120 0", out_valid, out_pc, out_pred_pc, out_pred_taken);
        end
        @(negedge clk_in);
        vec++; if (ic_req_addr !== 32'h120) begin errs++; $display("FAIL jal_next_req: got %h want 120", ic_req_addr); end
    endtask

    task automatic test_branch;
        redirect(32'h200);
`ifdef FETCH_BHT_EN
        respond(I_BEQ);
        vec++; if (out_pred_pc !== 32'h204 || out_pred_taken !== 1'b0) begin
            errs++; $display("FAIL bht_cold: pred %h tk %b want 204 0", out_pred_pc, out_pred_taken);
        end
        @(negedge clk_in);
        bht_upd_valid = 1'b1; bht_upd_pc = 32'h200; bht_upd_taken = 1'b1;
        repeat (2) @(negedge clk_in);
        bht_upd_valid = 1'b0;
        redirect(32'h200);
`endif
        respond(I_BEQ);
        vec++; if (out_pc !== 32'h200 || out_pred_pc !== 32'h1F8 || out_pred_taken !== 1'b1) begin
            errs++; $display("FAIL beq_taken: pc %h pred %h tk %b want 200 1f8 1", out_pc, out_pred_pc, out_pred_taken);
        end
        @(negedge clk_in);
        vec++; if (ic_req_addr !== 32'h1F8) begin errs++; $display("FAIL beq_next_req: got %h want 1f8", ic_req_addr); end
    endtask

    task automatic test_jalr;
        redirect(32'h40);
        respond(I_JALR);
        vec++; if (out_valid !== 1'b1 || out_pred_pc !== 32'h44 || out_pred_taken !== 1'b0) begin
            errs++; $display("FAIL jalr_deliver: v %b pred %h tk %b want 1 44 0", out_valid, out_pred_pc, out_pred_taken);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            vec++; if (ic_req_valid !== 1'b0) begin errs++; $display("FAIL jalr_stall_%0d: req_valid %b want 0", i, ic_req_valid); end
        end
        jalr_done_in = 1'b1; jalr_target_in = 32'h1235;
        @(negedge clk_in);
        jalr_done_in = 1'b0;
        @(negedge clk_in);
        vec++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h1234) begin
            errs++; $display("FAIL jalr_resume: valid %b addr %h want 1 1234", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_flush_jalr;
        redirect(32'h40);
        respond(I_JALR);
        flush_in = 1'b1; flush_pc = 32'h300; jalr_done_in = 1'b1; jalr_target_in = 32'h999;
        @(negedge clk_in);
        flush_in = 1'b0; jalr_done_in = 1'b0;
        @(negedge clk_in);
        vec++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h300) begin
            errs++; $display("FAIL flush_beats_jalr: valid %b addr %h want 1 300", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_flush_drain;
        flush_in = 1'b1; flush_pc = 32'h800;
        @(negedge clk_in);
        flush_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vec++; if (ic_req_valid !== 1'b0 || out_valid !== 1'b0) begin
                errs++; $display("FAIL drain_wait_%0d: req %b out %b want 0 0", i, ic_req_valid, out_valid);
            end
            @(negedge clk_in);
        end
        respond(I_ADDI1);
        vec++; if (out_valid !== 1'b0 || ic_req_valid !== 1'b0) begin
            errs++; $display("FAIL drain_discard: out %b req %b want 0 0", out_valid, ic_req_valid);
        end
        @(negedge clk_in);
        vec++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h800) begin
            errs++; $display("FAIL drain_refetch: valid %b addr %h want 1 800", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_flush_with_resp;
        flush_in = 1'b1; flush_pc = 32'h900;
        respond(I_ADDI1);
        flush_in = 1'b0;
        vec++; if (out_valid !== 1'b0 || ic_req_valid !== 1'b0) begin
            errs++; $display("FAIL flush_resp_nodeliver: out %b req %b want 0 0", out_valid, ic_req_valid);
        end
        @(negedge clk_in);
        vec++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h900) begin
            errs++; $display("FAIL flush_resp_refetch: valid %b addr %h want 1 900", ic_req_valid, ic_req_addr);
        end
    endtask

    task automatic test_iq_full;
        int pulses = 0;
        iq_full = 1'b1;
        respond(I_ADDI1);
        for (int i = 0; i < 5; i++) begin
            if (out_valid === 1'b1) pulses++;
            if (i == 0) begin
                vec++; if (ic_req_valid !== 1'b0) begin errs++; $display("FAIL iqfull_req_drop: got %b want 0", ic_req_valid); end
            end
            if (i < 4) @(negedge clk_in);
        end
        iq_full = 1'b0;
        @(negedge clk_in);
        vec++; if (out_valid !== 1'b1 || out_pc !== 32'h900 || out_inst !== I_ADDI1 || out_pred_pc !== 32'h904) begin
            errs++; $display("FAIL iqfull_deliver: v %b pc %h inst %h pred %h want 1 900 00100093 904", out_valid, out_pc, out_inst, out_pred_pc);
        end
        if (out_valid === 1'b1) pulses++;
        @(negedge clk_in);
        if (out_valid === 1'b1) pulses++;
        vec++; if (pulses !== 1) begin errs++; $display("FAIL iqfull_once: pulses %0d want 1", pulses); end
        vec++; if (ic_req_addr !== 32'h904) begin errs++; $display("FAIL iqfull_next_req: got %h want 904", ic_req_addr); end
    endtask

    task automatic test_rdy_stall;
        int pulses = 0;
        ic_resp_valid = 1'b1; ic_resp_inst = I_ADDI2;
        @(negedge clk_in);
        ic_resp_valid = 1'b0; rdy_in = 1'b0; #1;
        if (out_valid === 1'b1) pulses++;
        vec++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rdy_force0_a: got %b want 0", out_valid); end
        @(negedge clk_in);
        if (out_valid === 1'b1) pulses++;
        vec++; if (out_valid !== 1'b0 || ic_req_valid !== 1'b0) begin
            errs++; $display("FAIL rdy_hold: out %b req %b want 0 0", out_valid, ic_req_valid);
        end
        rdy_in = 1'b1; #1;
        if (out_valid === 1'b1) pulses++;
        vec++; if (out_valid !== 1'b1 || out_pc !== 32'h904 || out_pred_pc !== 32'h908) begin
            errs++; $display("FAIL rdy_resume: v %b pc %h pred %h want 1 904 908", out_valid, out_pc, out_pred_pc);
        end
        @(negedge clk_in);
        if (out_valid === 1'b1) pulses++;
        vec++; if (pulses !== 1) begin errs++; $display("FAIL rdy_once: pulses %0d want 1", pulses); end
        vec++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h908) begin
            errs++; $display("FAIL rdy_next_req: valid %b addr %h want 1 908", ic_req_valid, ic_req_addr);
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_jal;
        test_branch;
        test_jalr;
        test_flush_jalr;
        test_flush_drain;
        test_flush_with_resp;
        test_iq_full;
        test_rdy_stall;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
